clock_divider_multi: RTL
========================

Name: clock_divider_multi

Overview:
- Multi-channel programmable clock divider and tick generator. Parametrised successor to the single-channel LED toggle divider.
- NUM_CH independent channels, each with a runtime-writable WIDTH-bit terminal count.
- Each channel produces a 50% toggle output for LEDs and display strobes, and a one-cycle tick pulse for enabling downstream logic.
- Sits between the board clock and the display/timekeeping logic of the clock simulator.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- WIDTH, 28, width of each counter and terminal-count register.
- DEFAULT_DIV, 28'd49_999_999, terminal count loaded into every channel at reset.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  NUM_CH  per-channel count enable.
- wr_en  input  1  write strobe for the terminal-count register.
- wr_ch  input  4  channel index for the write.
- wr_data  input  WIDTH  new terminal count.
- out_level  output  NUM_CH  per-channel toggle output, registered.
- out_tick  output  NUM_CH  per-channel one-cycle pulse at terminal count, registered.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous-to-clock release):
  - every div[ch] = DEFAULT_DIV, cnt[ch] = 0;
  - out_level = 0, out_tick = 0.
- Per channel, each posedge, evaluated in this priority order:
  1. Write hit (wr_en=1, wr_ch==ch): div[ch] <= wr_data, cnt[ch] <= 0, out_tick[ch] <= 0. out_level[ch] holds. The write wins over counting in the same cycle.
  2. enable[ch]=0: cnt, div and out_level hold; out_tick[ch] <= 0.
  3. enable[ch]=1 and cnt[ch] >= div[ch]: cnt[ch] <= 0, out_level[ch] <= ~out_level[ch], out_tick[ch] <= 1.
  4. enable[ch]=1 otherwise: cnt[ch] <= cnt[ch]+1, out_tick[ch] <= 0.
- Timing with enable held high:
  - tick period = div+1 cycles;
  - out_level period = 2*(div+1) cycles, 50% duty.
- First terminal event after reset or after a write occurs on the (div+1)th enabled edge.
- div=0: out_tick held high every enabled cycle; out_level toggles every cycle (clock/2).
- The >= compare guarantees cnt never runs past div, so it never wraps through 2^WIDTH. The counter never exceeds div.
- wr_ch >= NUM_CH: write ignored, no state change.
- Channels are fully independent. Simultaneous enable and terminal events on different channels do not interact.
- No combinational path from inputs to outputs; output latency is one cycle after the qualifying edge.
- Reset asserted mid-count: all state is cleared immediately (asynchronously). No tick is emitted on the release edge.

Optional Feature:
- Macro: CLKDIV_PHASE_ALIGN_EN.
- Defined:
  - adds input port align (1 bit), placed after wr_data;
  - align=1 on a posedge forces every channel to cnt=0, out_level=0, out_tick=0;
  - align has priority above writes, and div registers are untouched;
  - used to phase-lock the seconds/minutes strobes after a time set.
- Undefined: port absent; the channels cannot be jointly re-phased except by reset.

Test Plan:
1. Reset then release, WIDTH=28, DEFAULT_DIV overridden to 3, enable=4'b0001 held -> out_tick[0] high on cycles 4, 8, 12; out_level[0] toggles 0->1 at cycle 4 and 1->0 at cycle 8; channels 1-3 stay 0.
2. Write wr_ch=2, wr_data=0, enable[2]=1 -> from the cycle after the write, out_tick[2]=1 every cycle and out_level[2] alternates every cycle.
3. Channel 1 at cnt=2 with div=5, then write wr_data=1 with enable high in the same cycle -> cnt restarts at 0, next tick 2 cycles later, out_level[1] unchanged by the write.
4. enable[0] dropped for 10 cycles mid-count (cnt=2, div=3) -> no tick and level frozen; after re-enable the tick arrives exactly 2 enabled cycles later.
5. wr_en with wr_ch=15 and NUM_CH=4 -> no div or cnt changes on any channel; output sequences match a run without the write.
6. reset_n pulsed low between edges mid-count -> out_level and out_tick go to 0 immediately (no clock edge needed); div returns to DEFAULT_DIV. With CLKDIV_PHASE_ALIGN_EN defined, a one-cycle align pulse gives all channels their first tick div+1 cycles later, simultaneously when their divs are equal.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable divider: per-channel 50% toggle level plus one-cycle terminal tick.
// Latency: outputs registered, one cycle after the qualifying edge. No backpressure; writes always accepted.
// Optional CLKDIV_PHASE_ALIGN_EN adds an align input that re-phases every channel at once.
module clock_divider_multi #(
    parameter int                 NUM_CH      = 4,
    parameter int                 WIDTH       = 28,
    parameter logic [WIDTH-1:0]   DEFAULT_DIV = WIDTH'(49_999_999)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     enable,
    input  logic                  wr_en,
    input  logic [3:0]            wr_ch,
    input  logic [WIDTH-1:0]      wr_data,
`ifdef CLKDIV_PHASE_ALIGN_EN
    input  logic                  align,
`endif
    output logic [NUM_CH-1:0]     out_level,
    output logic [NUM_CH-1:0]     out_tick
);

    logic [NUM_CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][WIDTH-1:0] div_q, div_d;
    logic [NUM_CH-1:0]            level_q, level_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic                         align_hit;

`ifdef CLKDIV_PHASE_ALIGN_EN
    assign align_hit = align;
`else
    assign align_hit = 1'b0;
`endif

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        level_d = level_q;
        tick_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (align_hit) begin
                cnt_d[i]   = '0;
                level_d[i] = 1'b0;
            end else if (wr_en && (wr_ch == 4'(i))) begin
                div_d[i] = wr_data;
                cnt_d[i] = '0;
            end else if (enable[i]) begin
                // >= rather than == so a shrinking div never lets cnt run past it
                if (cnt_q[i] >= div_q[i]) begin
                    cnt_d[i]   = '0;
                    level_d[i] = ~level_q[i];
                    tick_d[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            div_q   <= {NUM_CH{DEFAULT_DIV}};
            level_q <= '0;
            tick_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            level_q <= level_d;
            tick_q  <= tick_d;
        end
    end

    assign out_level = level_q;
    assign out_tick  = tick_q;

endmodule
